hamming_enc_stream: RTL and testbench

Parametrised, pipelined Hamming encoder with valid/ready streaming handshake on both sides. It generalises the fixed 8-bit combinational encoder to any data width from 4 to 57 bits, adds backpressure, registered outputs and a handshake-accurate word counter. It sits between a data producer and the storage/link path that needs protected codewords.

---
 rtl/hamming_enc_stream.sv | 139 +++++++++++++
 tb/tb_hamming_enc_stream.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_enc_stream.sv
// hamming_enc_stream
// ------------------
// Pipelined Hamming encoder with valid/ready handshakes on both sides.
// Stage A captures the incoming data word. Stage B holds the finished
// codeword. Parity is computed combinationally from stage A on the
// A->B transfer. At most two words are buffered.
//
// Parameters
//   DATA_W  data bits per word (4..57)
//   P       parity bit count, smallest P with 2^P >= DATA_W+P+1
//   CODE_W  DATA_W+P, plus one overall parity bit when SECDED is enabled
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    producer has a word
//   in_ready    block accepts a word this cycle
//   in_data     data word
//   out_valid   codeword available
//   out_ready   consumer accepts codeword
//   out_code    codeword; position i lives in out_code[i-1]
//   out_parity  Hamming parity bits; bit k is position 2^k
//   enc_count   number of delivered codewords, wraps at 16 bits
//
// Build option
//   HAMMING_SECDED_EN  adds out_code[CODE_W-1], the even parity of all
//                      other codeword bits, for double-error detection.
module hamming_enc_stream #(
  parameter int DATA_W = 8,
  localparam int P = (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 : 6,
`ifdef HAMMING_SECDED_EN
  localparam int CODE_W = DATA_W + P + 1
`else
  localparam int CODE_W = DATA_W + P
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [P-1:0]      out_parity,
  output logic [15:0]       enc_count
);

  localparam int DP = DATA_W + P;

  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic [CODE_W-1:0] b_code;
  logic [P-1:0]      b_parity;

  logic              advance;
  logic              in_fire;
  logic              out_fire;
  logic [CODE_W-1:0] code_c;
  logic [P-1:0]      par_c;

  // Stage A may hand its word to B whenever B is empty or B is being
  // emptied in the same cycle; this out_ready path is what gives full
  // throughput.
  assign advance   = a_valid && (!b_valid || out_ready);
  assign in_ready  = !a_valid || advance;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = b_valid && out_ready;

  assign out_valid  = b_valid;
  assign out_code   = b_code;
  assign out_parity = b_parity;

  // Scatter the data bits over the non-power-of-two positions, then
  // fold each position into the parity bits selected by its index.
  // Parity positions are still zero during the fold, so they do not
  // contribute to their own parity.
  always_comb begin
    int di;
    code_c = '0;
    par_c  = '0;
    di     = 0;
    for (int pos = 1; pos <= DP; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        code_c[pos-1] = a_data[di];
        di++;
      end
    end
    for (int k = 0; k < P; k++) begin
      for (int pos = 1; pos <= DP; pos++) begin
        if ((pos & (1 << k)) != 0) begin
          par_c[k] = par_c[k] ^ code_c[pos-1];
        end
      end
    end
    for (int k = 0; k < P; k++) begin
      code_c[(1 << k) - 1] = par_c[k];
    end
`ifdef HAMMING_SECDED_EN
    code_c[CODE_W-1] = ^code_c[DP-1:0];
`endif
  end

  // Reset discards both stages; it takes priority over any handshake
  // seen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_data    <= '0;
      b_valid   <= 1'b0;
      b_code    <= '0;
      b_parity  <= '0;
      enc_count <= 16'd0;
    end else begin
      if (in_fire) begin
        a_valid <= 1'b1;
        a_data  <= in_data;
      end else if (advance) begin
        a_valid <= 1'b0;
      end

      if (advance) begin
        b_valid  <= 1'b1;
        b_code   <= code_c;
        b_parity <= par_c;
      end else if (out_fire) begin
        b_valid <= 1'b0;
      end

      if (out_fire) begin
        enc_count <= enc_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Self-checking bench for hamming_enc_stream (DATA_W = 8).
// A reference model encodes each accepted word from the position rules:
// the parity vector is the XOR of the indices of all data positions
// holding a one. Outputs are compared on every cycle against a queue of
// accepted words.
module tb_hamming_enc_stream;

  localparam int DATA_W = 8;
  localparam int P = (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 : 6;
  localparam int DP = DATA_W + P;
`ifdef HAMMING_SECDED_EN
  localparam int CODE_W = DP + 1;
`else
  localparam int CODE_W = DP;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic [P-1:0]      out_parity;
  logic [15:0]       enc_count;

  int checks   = 0;
  int failures = 0;

  hamming_enc_stream #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_parity (out_parity),
    .enc_count  (enc_count)
  );

  always #5 clk = ~clk;

  // Reference encoder working from position indices rather than per-bit
  // parity equations.
  function automatic logic [CODE_W-1:0] model_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int syn;
    int j;
    c = '0;
    syn = 0;
    j = 0;
    for (int pos = 1; pos <= DP; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[j];
        if (d[j]) syn = syn ^ pos;
        j++;
      end
    end
    for (int k = 0; k < P; k++) c[(1 << k) - 1] = syn[k];
`ifdef HAMMING_SECDED_EN
    c[CODE_W-1] = ^c[DP-1:0];
`endif
    return c;
  endfunction

  function automatic logic [P-1:0] model_parity(input logic [DATA_W-1:0] d);
    int syn;
    int j;
    syn = 0;
    j = 0;
    for (int pos = 1; pos <= DP; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[j]) syn = syn ^ pos;
        j++;
      end
    end
    return P'(syn);
  endfunction

  function automatic int syndrome(input logic [CODE_W-1:0] c);
    int syn;
    syn = 0;
    for (int pos = 1; pos <= DP; pos++) if (c[pos-1]) syn = syn ^ pos;
    return syn;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    return DATA_W'({$urandom(), $urandom()});
  endfunction

  // Cycle-by-cycle comparison against the queue of accepted words.
  logic [DATA_W-1:0] model_q[$];
  logic [15:0]       model_cnt = 16'd0;
  logic              prev_rst  = 1'b0;
  logic              prev_hold = 1'b0;
  logic [CODE_W-1:0] prev_code;
  logic [P-1:0]      prev_par;

  always @(negedge clk) begin
    if (prev_rst) begin
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_enc_count", 64'(enc_count), 64'd0);
      checkOutput("rst_out_code", 64'(out_code), 64'd0);
      checkOutput("rst_out_parity", 64'(out_parity), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    end
    if (rst) begin
      model_q.delete();
      model_cnt = 16'd0;
      prev_hold = 1'b0;
    end else begin
      checkOutput("in_ready", 64'(in_ready), 64'(model_q.size() < 2 || out_ready));
      checkOutput("enc_count", 64'(enc_count), 64'(model_cnt));
      if (model_q.size() == 0) checkOutput("out_valid_empty", 64'(out_valid), 64'd0);
      if (prev_hold) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_code", 64'(out_code), 64'(prev_code));
        checkOutput("hold_parity", 64'(out_parity), 64'(prev_par));
      end
      if (out_valid && out_ready && model_q.size() > 0) begin
        checkOutput("out_code", 64'(out_code), 64'(model_encode(model_q[0])));
        checkOutput("out_parity", 64'(out_parity), 64'(model_parity(model_q[0])));
        checkOutput("syndrome", 64'(syndrome(out_code)), 64'd0);
`ifdef HAMMING_SECDED_EN
        checkOutput("overall_parity", 64'(^out_code), 64'd0);
`endif
        void'(model_q.pop_front());
        model_cnt = model_cnt + 16'd1;
      end
      if (in_valid && in_ready) model_q.push_back(in_data);
      prev_hold = out_valid && !out_ready;
      prev_code = out_code;
      prev_par  = out_parity;
    end
    prev_rst = rst;
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0]       cnt0;
    logic [DATA_W-1:0] w;
    bit                got;

    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);

    // Reset held for two cycles.
    step();
    step();
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_enc_count", 64'(enc_count), 64'd0);
    checkOutput("reset_out_code", 64'(out_code), 64'd0);
    step();
    rst = 1'b0;

    // Pin the model to a hand-computed vector.
    checkOutput("model_pin_code", 64'(model_encode(8'hAD)), 64'h0A6C);
    checkOutput("model_pin_parity", 64'(model_parity(8'hAD)), 64'h4);

    // Known vector and two-edge latency.
    applyStimulus(1'b1, 8'hAD, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("vec_not_yet_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("vec_valid", 64'(out_valid), 64'd1);
    checkOutput("vec_code", 64'(out_code), 64'h0A6C);
    checkOutput("vec_parity", 64'(out_parity), 64'h4);
    step();

    // Streaming: 100 back-to-back words after a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, rand_word(), 1'b1);
      @(negedge clk);
      checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (3) step();
    checkOutput("stream_enc_count", 64'(enc_count), 64'd100);

    // Backpressure: two words fill the pipe, the third must wait.
    cnt0 = enc_count;
    applyStimulus(1'b1, rand_word(), 1'b0);
    step();
    applyStimulus(1'b1, rand_word(), 1'b0);
    step();
    w = rand_word();
    applyStimulus(1'b1, w, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      step();
    end
    applyStimulus(1'b1, w, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      step();
    end
    checkOutput("bp_third_accepted", 64'(got), 64'd1);
    applyStimulus(1'b0, '0, 1'b1);
    repeat (4) step();
    checkOutput("bp_delivered", 64'(enc_count - cnt0), 64'd3);

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), rand_word(), ($urandom_range(0, 3) != 0));
      step();
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (3) step();

    // Reset while both stages are full; handshakes in that cycle ignored.
    applyStimulus(1'b1, rand_word(), 1'b0);
    step();
    applyStimulus(1'b1, rand_word(), 1'b0);
    step();
    rst = 1'b1;
    applyStimulus(1'b1, rand_word(), 1'b1);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_enc_count", 64'(enc_count), 64'd0);
    step();
    w = rand_word();
    applyStimulus(1'b1, w, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("midrst_latency_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("midrst_first_valid", 64'(out_valid), 64'd1);
    checkOutput("midrst_first_code", 64'(out_code), 64'(model_encode(w)));
    step();

    // Counter wrap: 65537 handshakes from zero.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      applyStimulus(1'b1, rand_word(), 1'b1);
      step();
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (3) step();
    checkOutput("wrap_enc_count", 64'(enc_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
